// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory line port between icache refills and dcache refills/writebacks.
// Define MEM_ARBITER_RR_EN for round-robin arbitration instead of fixed dcache priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 10,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ACC_I, ACC_D, RESP_I, RESP_D} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic              pick_d, acc;
`ifdef MEM_ARBITER_RR_EN
  logic last_q;
  // last_q = 1 when dcache was granted most recently; on a tie the other side wins
  assign pick_d = dc_req & ~(ic_req & last_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b0;
    else if (state_q == IDLE && (ic_req || dc_req)) last_q <= pick_d;
`else
  assign pick_d = dc_req;
`endif
  assign acc = state_q == ACC_I || state_q == ACC_D;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    case (state_q)
      IDLE: if (ic_req || dc_req) begin
        state_d = pick_d ? ACC_D : ACC_I;
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        addr_d  = pick_d ? dc_addr : ic_addr;
        we_d    = pick_d & dc_we;
        wdata_d = pick_d ? dc_wdata : '0;
      end
      ACC_I, ACC_D: if (cnt_q == '0) begin
        state_d    = state_q == ACC_I ? RESP_I : RESP_D;
        ic_rdata_d = state_q == ACC_I ? mem_rdata : ic_rdata_q;
        dc_rdata_d = (state_q == ACC_D && !we_q) ? mem_rdata : dc_rdata_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
    end
  assign mem_req   = acc;
  assign mem_we    = acc & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_ack    = state_q == RESP_I;
  assign dc_ack    = state_q == RESP_D;
  assign busy      = state_q != IDLE;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (latency 10 and 1) checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32, LW = 128;
  localparam logic [LW-1:0] PA5 = {4{32'hA5A5_A5A5}}, P12 = {4{32'h1234_5678}};
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_req[2], dc_req[2], dc_we[2], ic_ack[2], dc_ack[2], mem_req[2], mem_we[2], busy[2];
  logic [AW-1:0] ic_addr[2], dc_addr[2], mem_addr[2];
  logic [LW-1:0] dc_wdata[2], mem_rdata[2], ic_rdata[2], dc_rdata[2], mem_wdata[2];
  int vecs = 0, errs = 0, n;
  bit first_d;
  int m_t[2];
  bit m_d[2], m_we[2], m_last[2];
  logic [AW-1:0] m_addr[2];
  logic [LW-1:0] m_wd[2], m_ird[2], m_drd[2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.MEM_LATENCY(k == 0 ? 10 : 1)) u (
      .clk(clk), .reset(rst_n),
      .ic_req(ic_req[k]), .ic_addr(ic_addr[k]), .ic_ack(ic_ack[k]), .ic_rdata(ic_rdata[k]),
      .dc_req(dc_req[k]), .dc_we(dc_we[k]), .dc_addr(dc_addr[k]), .dc_wdata(dc_wdata[k]),
      .dc_ack(dc_ack[k]), .dc_rdata(dc_rdata[k]),
      .mem_req(mem_req[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k]), .busy(busy[k]));
  end
  function automatic int lat(int k);
    return k == 0 ? 10 : 1;
  endfunction
  function automatic bit win_d(int k);
`ifdef MEM_ARBITER_RR_EN
    return dc_req[k] && !(ic_req[k] && m_last[k]);
`else
    return dc_req[k];
`endif
  endfunction
  function automatic bit e_req(int k);
    return m_t[k] > 0 && m_t[k] <= lat(k);
  endfunction
  function automatic bit e_ack(int k);
    return m_t[k] == lat(k) + 1;
  endfunction
  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // m_t counts cycles since the grant: 1..L is the access, L+1 the ack cycle
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        m_t[k] <= 0;
        m_d[k] <= 1'b0;
        m_we[k] <= 1'b0;
        m_last[k] <= 1'b0;
        m_addr[k] <= '0;
        m_wd[k] <= '0;
        m_ird[k] <= '0;
        m_drd[k] <= '0;
      end else if (m_t[k] == 0) begin
        if (ic_req[k] || dc_req[k]) begin
          m_t[k] <= 1;
          m_d[k] <= win_d(k);
          m_last[k] <= win_d(k);
          m_addr[k] <= win_d(k) ? dc_addr[k] : ic_addr[k];
          m_we[k] <= win_d(k) && dc_we[k];
          m_wd[k] <= win_d(k) ? dc_wdata[k] : '0;
        end
      end else if (e_ack(k)) begin
        m_t[k] <= 0;
      end else begin
        if (m_t[k] == lat(k) && !m_d[k]) m_ird[k] <= mem_rdata[k];
        if (m_t[k] == lat(k) && m_d[k] && !m_we[k]) m_drd[k] <= mem_rdata[k];
        m_t[k] <= m_t[k] + 1;
      end
  task automatic chk(string nm, int k, logic [LW-1:0] got, logic [LW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, got, exp, $time);
    end
  endtask
  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk("mem_req", k, mem_req[k], e_req(k));
      chk("mem_we", k, mem_we[k], e_req(k) && m_we[k]);
      chk("mem_addr", k, mem_addr[k], m_addr[k]);
      chk("mem_wdata", k, mem_wdata[k], m_wd[k]);
      chk("ic_ack", k, ic_ack[k], e_ack(k) && !m_d[k]);
      chk("dc_ack", k, dc_ack[k], e_ack(k) && m_d[k]);
      chk("busy", k, busy[k], m_t[k] > 0);
      chk("ic_rdata", k, ic_rdata[k], m_ird[k]);
      chk("dc_rdata", k, dc_rdata[k], m_drd[k]);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (rst_n) cmp_all();
  endtask
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = rnd_line();
      if (ic_req[k] && e_ack(k) && !m_d[k]) ic_req[k] = 1'b0;
      else if (!ic_req[k] && $urandom_range(0, 2) == 0) begin
        ic_req[k] = 1'b1;
        ic_addr[k] = $urandom & 32'hFFFF_FFF0;
      end
      if (dc_req[k] && e_ack(k) && m_d[k]) dc_req[k] = 1'b0;
      else if (dc_req[k] && m_t[k] > 0 && m_d[k]) begin
        dc_addr[k] = $urandom & 32'hFFFF_FFF0;
        dc_wdata[k] = rnd_line();
      end else if (!dc_req[k] && $urandom_range(0, 2) == 0) begin
        dc_req[k] = 1'b1;
        dc_we[k] = 1'($urandom_range(0, 1));
        dc_addr[k] = $urandom & 32'hFFFF_FFF0;
        dc_wdata[k] = rnd_line();
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      ic_req[k] = 1'b0; dc_req[k] = 1'b0; dc_we[k] = 1'b0;
      ic_addr[k] = '0; dc_addr[k] = '0; dc_wdata[k] = '0; mem_rdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mem_req", 0, mem_req[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_mem_addr", 0, mem_addr[0], 0);
    chk("rst_ic_rdata", 0, ic_rdata[0], 0);
    // single icache refill
    ic_req[0] = 1'b1; ic_addr[0] = 32'h40; mem_rdata[0] = PA5;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 1 || i == 10) begin
        chk("t1_req", 0, mem_req[0], 1);
        chk("t1_addr", 0, mem_addr[0], 32'h40);
        chk("t1_we", 0, mem_we[0], 0);
      end
      if (i == 11) begin
        chk("t1_ack", 0, ic_ack[0], 1);
        chk("t1_rdata", 0, ic_rdata[0], PA5);
        chk("t1_req_off", 0, mem_req[0], 0);
        ic_req[0] = 1'b0;
      end
      if (i == 12) chk("t1_busy", 0, busy[0], 0);
    end
    // dcache writeback
    dc_req[0] = 1'b1; dc_we[0] = 1'b1; dc_addr[0] = 32'h100; dc_wdata[0] = P12; mem_rdata[0] = ~P12;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 1 || i == 10) begin
        chk("t2_we", 0, mem_we[0], 1);
        chk("t2_wdata", 0, mem_wdata[0], P12);
        chk("t2_addr", 0, mem_addr[0], 32'h100);
      end
      if (i == 11) begin
        chk("t2_ack", 0, dc_ack[0], 1);
        chk("t2_ic_ack", 0, ic_ack[0], 0);
        chk("t2_rdata", 0, dc_rdata[0], 0);
        dc_req[0] = 1'b0; dc_we[0] = 1'b0;
      end
    end
    // simultaneous requests; after the writeback round-robin favours icache
`ifdef MEM_ARBITER_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    ic_req[0] = 1'b1; ic_addr[0] = 32'h200; dc_req[0] = 1'b1; dc_addr[0] = 32'h300;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      if (i == 1) chk("t3_first_addr", 0, mem_addr[0], first_d ? 32'h300 : 32'h200);
      if (i == 11) begin
        chk("t3_first_ack", 0, first_d ? dc_ack[0] : ic_ack[0], 1);
        if (first_d) dc_req[0] = 1'b0; else ic_req[0] = 1'b0;
      end
      if (i == 12) chk("t3_turnaround", 0, busy[0], 0);
      if (i == 13) begin
        chk("t3_second_addr", 0, mem_addr[0], first_d ? 32'h200 : 32'h300);
        chk("t3_second_req", 0, mem_req[0], 1);
      end
      if (i == 23) begin
        chk("t3_second_ack", 0, first_d ? ic_ack[0] : dc_ack[0], 1);
        ic_req[0] = 1'b0; dc_req[0] = 1'b0;
      end
    end
    // latency 1, back-to-back dcache refills
    dc_req[1] = 1'b1; dc_we[1] = 1'b0; dc_addr[1] = 32'h80; mem_rdata[1] = PA5;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 1 || i == 4) chk("t6_req", 1, mem_req[1], 1);
      if (i == 2) begin
        chk("t6_ack1", 1, dc_ack[1], 1);
        chk("t6_rdata1", 1, dc_rdata[1], PA5);
        mem_rdata[1] = P12;
      end
      if (i == 3) begin
        chk("t6_idle", 1, busy[1], 0);
        chk("t6_ack_pulse", 1, dc_ack[1], 0);
      end
      if (i == 5) begin
        chk("t6_ack2", 1, dc_ack[1], 1);
        chk("t6_rdata2", 1, dc_rdata[1], P12);
        dc_req[1] = 1'b0;
      end
    end
    // reset in the middle of the 5th access cycle
    dc_req[0] = 1'b1; dc_we[0] = 1'b0; dc_addr[0] = 32'h500; mem_rdata[0] = PA5;
    repeat (5) cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req", 0, mem_req[0], 0);
    chk("t5_dc_ack", 0, dc_ack[0], 0);
    chk("t5_busy", 0, busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      if (i == 1) chk("t5_addr", 0, mem_addr[0], 32'h500);
      if (i == 10) chk("t5_req", 0, mem_req[0], 1);
      if (i == 11) begin
        chk("t5_ack", 0, dc_ack[0], 1);
        dc_req[0] = 1'b0;
      end
    end
    // both held continuously from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ic_req[0] = 1'b1; ic_addr[0] = 32'h600; dc_req[0] = 1'b1; dc_addr[0] = 32'h700;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      cyc();
      if (ic_ack[0] || dc_ack[0]) begin
`ifdef MEM_ARBITER_RR_EN
        chk("t4_grant", 0, dc_ack[0], n % 2 == 0);
`else
        chk("t4_grant", 0, dc_ack[0], 1);
`endif
        n++;
      end
    end
    chk("t4_count", 0, n, 4);
    ic_req[0] = 1'b0; dc_req[0] = 1'b0;
    repeat (3000) begin
      cyc();
      drive();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
